ps2_key_injector: RTL and testbench

//  Generates 11-bit ps2_key event words (the format consumed by the keyboard matrix decoder) from a

---
 rtl/ps2_key_injector.sv | 196 +++++++++++++++++++
 tb/tb_ps2_key_injector.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_injector.sv
// ps2_key_injector: merges the live HPS ps2_key stream with scancode events
// injected from a request FIFO (autotype / paste / scripted keys).
// Host events always win. Injected events are spaced so that software
// scanning the keyboard matrix sees every press and every release.
module ps2_key_injector #(
    parameter int FIFO_DEPTH = 16,    // power of 2, >= 2
    parameter int GAP_CYCLES = 50000  // >= 2
) (
    input  logic                          clk_sys,
    input  logic                          reset_n,
    input  logic [10:0]                   host_key,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_code,
    input  logic                          in_ext,
    input  logic                          in_press,
    input  logic                          in_auto,
    output logic [10:0]                   ps2_key,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(GAP_CYCLES);

    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    typedef struct packed {
        logic       is_auto;
        logic       press;
        logic       ext;
        logic [7:0] code;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_REL_GAP,
        S_REL
    } state_t;

    // Request FIFO storage and control
    entry_t          r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_ready;
    logic            r_avail;
    logic [CW-1:0]   w_count_next;
    logic            w_push;
    logic            w_pop;
    entry_t          w_in_entry;
    entry_t          w_head;

    // Injector FSM
    state_t          r_state;
    state_t          w_state_next;
    logic [GW-1:0]   r_cnt;
    logic [GW-1:0]   w_cnt_next;
    logic            r_busy;
    logic            r_hold_ext;
    logic [7:0]      r_hold_code;
    logic            w_inj_emit;
    logic [9:0]      w_inj_word;

    // Host path and output word
    logic            r_old_host;
    logic            w_host_evt;
    logic            r_tog;
    logic [10:0]     r_ps2_key;

    assign w_push     = in_valid & r_ready;
    assign w_in_entry = '{is_auto: in_auto, press: in_press, ext: in_ext, code: in_code};
    assign w_head     = r_mem[r_rd_ptr];
    assign w_host_evt = host_key[10] ^ r_old_host;

    assign in_ready   = r_ready;
    assign fifo_count = r_count;
    assign busy       = r_busy;
    assign ps2_key    = r_ps2_key;

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // FIFO storage write
    // NOTE: the entry array carries no reset; a flush only clears pointers and count.
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    // FIFO pointers, count, registered ready, and the delayed "entry visible" flag
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
            r_avail  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_ready <= (w_count_next < DEPTH_C);
            // A pushed entry becomes visible to the injector one cycle later,
            // so push-to-output is two edges. Any pop leaves IDLE for at least
            // two cycles, so this lagging flag is current whenever IDLE reads it.
            r_avail <= (r_count != '0);
        end
    end

    // Injector next-state, gap counter and emit decision
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pop        = 1'b0;
        w_inj_emit   = 1'b0;
        w_inj_word   = '0;
        case (r_state)
            S_IDLE: begin
                if (r_avail && !w_host_evt) begin
                    w_pop        = 1'b1;
                    w_inj_emit   = 1'b1;
                    w_inj_word   = {w_head.is_auto | w_head.press, w_head.ext, w_head.code};
                    w_cnt_next   = GAP_LOAD;
                    w_state_next = w_head.is_auto ? S_REL_GAP : S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) w_state_next = S_IDLE;
                else             w_cnt_next   = r_cnt - 1'b1;
            end
            S_REL_GAP: begin
                if (r_cnt == '0) w_state_next = S_REL;
                else             w_cnt_next   = r_cnt - 1'b1;
            end
            S_REL: begin
                if (!w_host_evt) begin
                    w_inj_emit   = 1'b1;
                    w_inj_word   = {1'b0, r_hold_ext, r_hold_code};
                    w_cnt_next   = GAP_LOAD;
                    w_state_next = S_GAP;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Injector state, counter, busy flag and the entry held for auto-release
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_hold_ext  <= 1'b0;
            r_hold_code <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_busy  <= (w_count_next != '0) | (w_state_next != S_IDLE);
            if (w_pop) begin
                r_hold_ext  <= w_head.ext;
                r_hold_code <= w_head.code;
            end
        end
    end

    // Output word: host events first, then injected events; each flips the toggle
    always_ff @(posedge clk_sys) begin
        // Host toggle history is resampled during reset so no stale event fires after it.
        r_old_host <= host_key[10];
        if (!reset_n) begin
            r_tog     <= 1'b0;
            r_ps2_key <= '0;
        end else if (w_host_evt) begin
            r_ps2_key <= {~r_tog, host_key[9:0]};
            r_tog     <= ~r_tog;
        end else if (w_inj_emit) begin
            r_ps2_key <= {~r_tog, w_inj_word};
            r_tog     <= ~r_tog;
        end
    end

endmodule

// File: tb/tb_ps2_key_injector.sv
// Directed bench for ps2_key_injector with a short gap and a 4-entry FIFO.
module tb_ps2_key_injector;

    localparam int DEPTH = 4;
    localparam int GAP   = 8;

    logic                      clk_sys;
    logic                      reset_n;
    logic [10:0]               host_key;
    logic                      in_valid;
    logic                      in_ready;
    logic [7:0]                in_code;
    logic                      in_ext;
    logic                      in_press;
    logic                      in_auto;
    logic [10:0]               ps2_key;
    logic                      busy;
    logic [$clog2(DEPTH):0]    fifo_count;

    int n_cmp;
    int n_err;

    ps2_key_injector #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .host_key   (host_key),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_ext     (in_ext),
        .in_press   (in_press),
        .in_auto    (in_auto),
        .ps2_key    (ps2_key),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push(input logic [7:0] code, input logic ext, input logic press, input logic auto_f);
        in_code  = code;
        in_ext   = ext;
        in_press = press;
        in_auto  = auto_f;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Waits until ps2_key changes, returning the number of edges taken.
    task automatic wait_evt(input string tag, input int budget, output int n);
        logic [10:0] prev;
        prev = ps2_key;
        n    = 0;
        while ((ps2_key === prev) && (n < budget)) begin
            tick();
            n++;
        end
        check({tag, " seen"}, 32'(ps2_key !== prev), 32'd1);
    endtask

    initial begin
        int n;
        logic [31:0] exp_rdy [7];
        logic [31:0] exp_cnt [7];
        logic [10:0] exp_tail [4];
        n_cmp    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        host_key = '0;
        in_valid = 1'b0;
        in_code  = '0;
        in_ext   = 1'b0;
        in_press = 1'b0;
        in_auto  = 1'b0;

        // 1: reset state, single press, then release spaced by GAP+1
        repeat (3) tick();
        check("rst ps2_key", ps2_key, 32'h000);
        check("rst in_ready", in_ready, 32'd1);
        check("rst busy", busy, 32'd0);
        check("rst fifo_count", fifo_count, 32'd0);
        reset_n = 1'b1;
        tick();

        push(8'h1C, 1'b0, 1'b1, 1'b0);
        check("t1 busy after push", busy, 32'd1);
        wait_evt("t1 press", 10, n);
        check("t1 press latency", n, 32'd2);
        check("t1 press word", ps2_key, 32'h61C);
        push(8'h1C, 1'b0, 1'b0, 1'b0);
        wait_evt("t1 release", GAP + 10, n);
        check("t1 release spacing", n + 1, GAP + 1);
        check("t1 release word", ps2_key, 32'h01C);
        repeat (GAP - 1) tick();
        check("t1 busy in gap", busy, 32'd1);
        tick();
        check("t1 busy idle", busy, 32'd0);

        // 2: auto press/release pair
        push(8'h75, 1'b1, 1'b0, 1'b1);
        wait_evt("t2 press", 10, n);
        check("t2 press latency", n, 32'd2);
        check("t2 press word", ps2_key, 32'h775);
        wait_evt("t2 release", GAP + 10, n);
        check("t2 release spacing", n, GAP + 1);
        check("t2 release word", ps2_key, 32'h175);
        repeat (GAP) tick();
        check("t2 busy idle", busy, 32'd0);
        check("t2 fifo empty", fifo_count, 32'd0);

        // 3: overfill with in_valid held; pop of the first entry happens on the third edge
        exp_rdy = '{1, 1, 1, 1, 1, 0, 0};
        exp_cnt = '{1, 2, 2, 3, 4, 4, 4};
        in_ext   = 1'b0;
        in_press = 1'b1;
        in_auto  = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_code  = 8'h20 + 8'(i);
            in_valid = 1'b1;
            check($sformatf("t3 in_ready %0d", i), in_ready, exp_rdy[i]);
            tick();
            check($sformatf("t3 fifo_count %0d", i), fifo_count, exp_cnt[i]);
        end
        in_valid = 1'b0;
        check("t3 first word", ps2_key, 32'h620);
        exp_tail = '{11'h221, 11'h622, 11'h223, 11'h624};
        for (int k = 0; k < 4; k++) begin
            wait_evt($sformatf("t3 evt %0d", k), GAP + 10, n);
            check($sformatf("t3 spacing %0d", k), n, (k == 0) ? GAP - 3 : GAP + 1);
            check($sformatf("t3 word %0d", k), ps2_key, 32'(exp_tail[k]));
        end
        check("t3 drained", fifo_count, 32'd0);
        check("t3 ready again", in_ready, 32'd1);

        // 4: host toggle collides with a due injected emit, then a host event mid-gap
        repeat (GAP + 2) tick();
        check("t4 idle", busy, 32'd0);
        push(8'h30, 1'b0, 1'b1, 1'b0);
        tick();
        check("t4 not yet", ps2_key, 32'h624);
        host_key = {~host_key[10], 1'b1, 1'b1, 8'h5A};
        tick();
        check("t4 host first", ps2_key, 32'h35A);
        tick();
        check("t4 injected next", ps2_key, 32'h630);
        push(8'h31, 1'b0, 1'b0, 1'b0);
        host_key = {~host_key[10], 1'b0, 1'b1, 8'h5A};
        tick();
        check("t4 host in gap", ps2_key, 32'h15A);
        wait_evt("t4 queued", GAP + 10, n);
        check("t4 gap unaffected", n, GAP - 1);
        check("t4 queued word", ps2_key, 32'h431);

        // 5: reset during REL_GAP with 3 entries queued
        repeat (GAP + 2) tick();
        push(8'h40, 1'b0, 1'b1, 1'b1);
        push(8'h41, 1'b0, 1'b1, 1'b0);
        push(8'h42, 1'b0, 1'b1, 1'b0);
        push(8'h43, 1'b0, 1'b1, 1'b0);
        check("t5 queued", fifo_count, 32'd3);
        check("t5 auto press", ps2_key, 32'h240);
        check("t5 busy", busy, 32'd1);
        reset_n  = 1'b0;
        host_key = {~host_key[10], 1'b1, 1'b0, 8'h11};
        tick();
        check("t5 rst ps2_key", ps2_key, 32'h000);
        check("t5 rst fifo_count", fifo_count, 32'd0);
        check("t5 rst busy", busy, 32'd0);
        check("t5 rst in_ready", in_ready, 32'd1);
        reset_n = 1'b1;
        repeat (2 * GAP + 4) tick();
        check("t5 nothing emitted", ps2_key, 32'h000);
        check("t5 still empty", fifo_count, 32'd0);
        push(8'h55, 1'b0, 1'b1, 1'b0);
        wait_evt("t5 new push", 10, n);
        check("t5 new latency", n, 32'd2);
        check("t5 new word", ps2_key, 32'h655);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
